cube_sqrt_sum: RTL

CUBE_SQRT_SUM -- requirements
Module: cube_sqrt_sum

---
 rtl/cube_sqrt_sum.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cube_sqrt_sum.sv
// cube_sqrt_sum: computes y = a^3 + floor(sqrt(b)) with bit-serial datapaths.
// Sequence: IDLE -> SQ (W cycles: a*a shift-add plus W/2-step integer root)
// -> CU (W cycles: (a*a)*a shift-add) -> SUM (1 cycle, loads y, pulses valid).
// Optional feature: define CUBE_SQRT_RESTART_EN to let start_i abort and
// restart a busy operation; without it, start_i is ignored while busy.
module cube_sqrt_sum #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           valid_o,
    output logic [3*W-1:0] y_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int H  = W / 2;
    localparam int RW = H + 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SQ   = 2'd1;
    localparam logic [1:0] CU   = 2'd2;
    localparam logic [1:0] SUM  = 2'd3;

    logic [1:0]     state_r;
    logic [CW-1:0]  cnt_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_sh_r;
    logic [2*W-1:0] sq_r;
    logic [3*W-1:0] cu_r;
    logic [H:0]     rem_r;
    logic [H-1:0]   root_r;

    logic [2*W-1:0] sq_add_s;
    logic [3*W-1:0] cu_add_s;
    logic [H+1:0]   step_s;
    logic           take_s;

    // One restoring square-root iteration: bring down the next two radicand
    // bits and try to subtract (4*root + 1). Returns {root_bit, new_remainder}.
    // The remainder never exceeds 2*root, so H+1 bits always hold it.
    function automatic logic [H+1:0] sqrt_step(input logic [H:0]   rem,
                                               input logic [1:0]   pair,
                                               input logic [H-1:0] root);
        logic [RW-1:0] trial;
        logic [RW-1:0] test;
        logic [RW-1:0] diff;
        trial = {rem, pair};
        test  = {1'b0, root, 2'b01};
        diff  = trial - test;
        if (trial >= test) begin
            sqrt_step = {1'b1, diff[H:0]};
        end else begin
            sqrt_step = {1'b0, trial[H:0]};
        end
    endfunction

    // Partial products, root step and start-acceptance decode for this cycle.
    always_comb begin
        sq_add_s = {(2*W){1'b0}};
        cu_add_s = {(3*W){1'b0}};
        if (a_r[cnt_r]) begin
            sq_add_s = {{W{1'b0}}, a_r} << cnt_r;
            cu_add_s = {{W{1'b0}}, sq_r} << cnt_r;
        end else begin
            sq_add_s = {(2*W){1'b0}};
            cu_add_s = {(3*W){1'b0}};
        end
        step_s = sqrt_step(rem_r, b_sh_r[W-1:W-2], root_r);
`ifdef CUBE_SQRT_RESTART_EN
        take_s = start_i;
`else
        take_s = start_i && (state_r == IDLE);
`endif
    end

    // Sequencer and datapath registers; reset wins over start and over any operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            a_r     <= {W{1'b0}};
            b_sh_r  <= {W{1'b0}};
            sq_r    <= {(2*W){1'b0}};
            cu_r    <= {(3*W){1'b0}};
            rem_r   <= {(H+1){1'b0}};
            root_r  <= {H{1'b0}};
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            y_o     <= {(3*W){1'b0}};
        end else begin
            valid_o <= 1'b0;
            if (take_s) begin
                state_r <= SQ;
                cnt_r   <= {CW{1'b0}};
                a_r     <= a_i;
                b_sh_r  <= b_i;
                sq_r    <= {(2*W){1'b0}};
                cu_r    <= {(3*W){1'b0}};
                rem_r   <= {(H+1){1'b0}};
                root_r  <= {H{1'b0}};
                busy_o  <= 1'b1;
            end else begin
                case (state_r)
                    SQ: begin
                        sq_r <= sq_r + sq_add_s;
                        if (cnt_r < CW'(H)) begin
                            rem_r  <= step_s[H:0];
                            root_r <= {root_r[H-2:0], step_s[H+1]};
                            b_sh_r <= {b_sh_r[W-3:0], 2'b00};
                        end else begin
                            rem_r  <= rem_r;
                            root_r <= root_r;
                            b_sh_r <= b_sh_r;
                        end
                        if (cnt_r == CW'(W-1)) begin
                            cnt_r   <= {CW{1'b0}};
                            state_r <= CU;
                        end else begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    CU: begin
                        cu_r <= cu_r + cu_add_s;
                        if (cnt_r == CW'(W-1)) begin
                            cnt_r   <= {CW{1'b0}};
                            state_r <= SUM;
                        end else begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    SUM: begin
                        y_o     <= cu_r + {{(3*W-H){1'b0}}, root_r};
                        valid_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
